// File: rtl/depp_pkg.sv
// Shared definitions for the EPP slave: FSM state encodings and EPP bus polarities.
package depp_pkg;

    localparam int EPP_W = 8;

    // Host-side strobes are active-low; depp_write low means the host is writing
    localparam logic STB_ACTIVE  = 1'b0;
    localparam logic DIR_HOST_WR = 1'b0;
    localparam logic WAIT_DONE   = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AWR  = 3'd1,
        ST_ARD  = 3'd2,
        ST_DWR  = 3'd3,
        ST_DRD  = 3'd4,
        ST_HOLD = 3'd5
    } depp_state_t;

endpackage

// File: rtl/depp_sync.sv
// Multi-flop synchronizer for one asynchronous EPP control line; resets to the idle (high) level.
module depp_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_r;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_r <= '1;
        end else begin
            sync_r <= {sync_r[STAGES-2:0], d};
        end
    end

    assign q = sync_r[STAGES-1];

endmodule

// File: rtl/depp_epp_slave.sv
// EPP slave: synchronizes the host handshake and maps address/data cycles onto a register file.
module depp_epp_slave
    import depp_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int AUTO_INC    = 0
) (
    input  logic             clk,
    input  logic             rst,
    inout  wire  [EPP_W-1:0] depp_db,
    input  logic             depp_astb,
    input  logic             depp_dstb,
    input  logic             depp_write,
    output logic             depp_wait,
    output logic             mem_we,
    output logic [EPP_W-1:0] mem_adr,
    output logic [EPP_W-1:0] mem_idata,
    input  logic [EPP_W-1:0] mem_odata
);

    logic             astb_s;
    logic             dstb_s;
    logic             write_s;
    depp_state_t      state;
    logic [EPP_W-1:0] addr_r;
    logic [EPP_W-1:0] db_r;
    logic [EPP_W-1:0] rd_r;
    logic             drv;
    logic             data_cyc;

    depp_sync #(.STAGES(SYNC_STAGES)) u_sync_astb (.clk(clk), .rst(rst), .d(depp_astb),  .q(astb_s));
    depp_sync #(.STAGES(SYNC_STAGES)) u_sync_dstb (.clk(clk), .rst(rst), .d(depp_dstb),  .q(dstb_s));
    depp_sync #(.STAGES(SYNC_STAGES)) u_sync_wr   (.clk(clk), .rst(rst), .d(depp_write), .q(write_s));

    assign depp_db   = drv ? rd_r : {EPP_W{1'bz}};
    assign mem_adr   = addr_r;
    assign mem_idata = db_r;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            depp_wait <= 1'b0;
            mem_we    <= 1'b0;
            drv       <= 1'b0;
            addr_r    <= '0;
            db_r      <= '0;
            rd_r      <= '0;
            data_cyc  <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                // Direction is latched here only; the address strobe wins a tie
                ST_IDLE: begin
                    if (astb_s == STB_ACTIVE) begin
                        data_cyc <= 1'b0;
                        if (write_s == DIR_HOST_WR) begin
                            db_r  <= depp_db;
                            state <= ST_AWR;
                        end else begin
                            state <= ST_ARD;
                        end
                    end else if (dstb_s == STB_ACTIVE) begin
                        data_cyc <= 1'b1;
                        if (write_s == DIR_HOST_WR) begin
                            db_r   <= depp_db;
                            mem_we <= 1'b1;
                            state  <= ST_DWR;
                        end else begin
                            state <= ST_DRD;
                        end
                    end
                end
                ST_AWR: begin
                    addr_r    <= db_r;
                    depp_wait <= WAIT_DONE;
                    state     <= ST_HOLD;
                end
                ST_DWR: begin
                    depp_wait <= WAIT_DONE;
                    state     <= ST_HOLD;
                end
                ST_ARD: begin
                    rd_r      <= addr_r;
                    drv       <= 1'b1;
                    depp_wait <= WAIT_DONE;
                    state     <= ST_HOLD;
                end
                ST_DRD: begin
                    rd_r      <= mem_odata;
                    drv       <= 1'b1;
                    depp_wait <= WAIT_DONE;
                    state     <= ST_HOLD;
                end
                // Wait for the host to release both strobes before accepting a new cycle
                ST_HOLD: begin
                    if (astb_s != STB_ACTIVE && dstb_s != STB_ACTIVE) begin
                        depp_wait <= ~WAIT_DONE;
                        drv       <= 1'b0;
                        state     <= ST_IDLE;
                        if (AUTO_INC != 0 && data_cyc) begin
                            addr_r <= addr_r + 8'd1;
                        end
                    end
                end
                default: begin
                    depp_wait <= ~WAIT_DONE;
                    drv       <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_depp_epp_slave.sv
// Bench for depp_epp_slave: drives one EPP host into a plain and an auto-increment instance side by side.
`timescale 1ns/1ps
module tb_depp_epp_slave;

    localparam int SS = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       depp_astb = 1'b1;
    logic       depp_dstb = 1'b1;
    logic       depp_write = 1'b1;
    logic       host_drive = 1'b0;
    logic [7:0] host_db = 8'h00;

    wire  [7:0] db0;
    wire  [7:0] db1;
    logic       depp_wait0, depp_wait1;
    logic       mem_we0, mem_we1;
    logic [7:0] mem_adr0, mem_adr1;
    logic [7:0] mem_idata0, mem_idata1;
    logic [7:0] mem_odata0, mem_odata1;

    logic       ld_en = 1'b0;
    logic [7:0] ld_adr = 8'h00;
    logic [7:0] ld_dat = 8'h00;
    logic [7:0] mem0 [256];
    logic [7:0] mem1 [256];

    logic [7:0]  mem_m0 [256];
    logic [7:0]  mem_m1 [256];
    logic [7:0]  addr_m0, addr_m1;
    logic [15:0] wq0 [$];
    logic [15:0] wq1 [$];

    int n_checks = 0;
    int n_fail   = 0;
    int fall_cyc;

    assign db0 = host_drive ? host_db : 8'hzz;
    assign db1 = host_drive ? host_db : 8'hzz;

    always #62 clk = ~clk;

    depp_epp_slave #(.SYNC_STAGES(SS), .AUTO_INC(0)) dut0 (
        .clk(clk), .rst(rst), .depp_db(db0), .depp_astb(depp_astb), .depp_dstb(depp_dstb),
        .depp_write(depp_write), .depp_wait(depp_wait0), .mem_we(mem_we0), .mem_adr(mem_adr0),
        .mem_idata(mem_idata0), .mem_odata(mem_odata0)
    );

    depp_epp_slave #(.SYNC_STAGES(SS), .AUTO_INC(1)) dut1 (
        .clk(clk), .rst(rst), .depp_db(db1), .depp_astb(depp_astb), .depp_dstb(depp_dstb),
        .depp_write(depp_write), .depp_wait(depp_wait1), .mem_we(mem_we1), .mem_adr(mem_adr1),
        .mem_idata(mem_idata1), .mem_odata(mem_odata1)
    );

    assign mem_odata0 = mem0[mem_adr0];
    assign mem_odata1 = mem1[mem_adr1];

    always @(posedge clk) begin
        if (ld_en) begin
            mem0[ld_adr] <= ld_dat;
            mem1[ld_adr] <= ld_dat;
        end else begin
            if (mem_we0) mem0[mem_adr0] <= mem_idata0;
            if (mem_we1) mem1[mem_adr1] <= mem_idata1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Write scoreboard: every mem_we pulse must match the oldest outstanding host write
    always @(negedge clk) begin
        if (mem_we0) begin
            if (wq0.size() == 0) check_eq("we0_unexpected", {31'b0, mem_we0}, 32'd0);
            else check_eq("we0_adr_dat", {16'b0, mem_adr0, mem_idata0}, {16'b0, wq0.pop_front()});
        end
        if (mem_we1) begin
            if (wq1.size() == 0) check_eq("we1_unexpected", {31'b0, mem_we1}, 32'd0);
            else check_eq("we1_adr_dat", {16'b0, mem_adr1, mem_idata1}, {16'b0, wq1.pop_front()});
        end
    end

    task automatic host_cycle(input bit a_lo, input bit d_lo, input bit rd, input logic [7:0] wd,
                              input int hold_cyc, input string tag, output int fall_n);
        logic [7:0] exp0, exp1;
        bit seen;
        int n;
        exp0 = 8'h00;
        exp1 = 8'h00;
        if (a_lo) begin
            if (!rd) begin
                addr_m0 = wd;
                addr_m1 = wd;
            end else begin
                exp0 = addr_m0;
                exp1 = addr_m1;
            end
        end else begin
            if (!rd) begin
                wq0.push_back({addr_m0, wd});
                wq1.push_back({addr_m1, wd});
                mem_m0[addr_m0] = wd;
                mem_m1[addr_m1] = wd;
            end else begin
                exp0 = mem_m0[addr_m0];
                exp1 = mem_m1[addr_m1];
            end
            addr_m1 = addr_m1 + 8'd1;
        end
        @(negedge clk);
        depp_write = rd;
        host_drive = !rd;
        host_db    = wd;
        depp_astb  = !a_lo;
        depp_dstb  = !d_lo;
        seen = 1'b0;
        for (n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == hold_cyc) begin
                depp_astb = 1'b1;
                depp_dstb = 1'b1;
            end
            if (depp_wait0) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq($sformatf("%s_wait_rise", tag), {31'b0, seen}, 32'd1);
        check_eq($sformatf("%s_wait1_rise", tag), {31'b0, depp_wait1}, 32'd1);
        if (rd) begin
            check_eq($sformatf("%s_rd0", tag), {24'b0, db0}, {24'b0, exp0});
            check_eq($sformatf("%s_rd1", tag), {24'b0, db1}, {24'b0, exp1});
        end
        depp_astb = 1'b1;
        depp_dstb = 1'b1;
        seen = 1'b0;
        fall_n = 0;
        for (n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (!depp_wait0) begin
                seen = 1'b1;
                fall_n = n;
                break;
            end
        end
        check_eq($sformatf("%s_wait_fall", tag), {31'b0, seen}, 32'd1);
        check_eq($sformatf("%s_wait1_fall", tag), {31'b0, depp_wait1}, 32'd0);
        check_eq($sformatf("%s_bus_rel0", tag), {31'b0, dut0.drv}, 32'd0);
        check_eq($sformatf("%s_bus_rel1", tag), {31'b0, dut1.drv}, 32'd0);
        host_drive = 1'b0;
        depp_write = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        addr_m0 = 8'h00;
        addr_m1 = 8'h00;
        mem_m0[8'h85] = 8'h5A;
        mem_m1[8'h85] = 8'h5A;
        #5 rst = 1'b0;
        @(negedge clk);
        ld_en = 1'b1; ld_adr = 8'h85; ld_dat = 8'h5A;
        @(negedge clk);
        ld_en = 1'b0;
        check_eq("rst_wait0", {31'b0, depp_wait0}, 32'd0);
        check_eq("rst_we0",   {31'b0, mem_we0}, 32'd0);
        check_eq("rst_adr0",  {24'b0, mem_adr0}, 32'd0);
        check_eq("rst_drv0",  {31'b0, dut0.drv}, 32'd0);
        check_eq("rst_wait1", {31'b0, depp_wait1}, 32'd0);
        check_eq("rst_adr1",  {24'b0, mem_adr1}, 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        host_cycle(1'b1, 1'b0, 1'b0, 8'h05, 0, "awr05", fall_cyc);
        check_eq("awr05_fall_cycles", fall_cyc, SS + 1);
        check_eq("awr05_adr0", {24'b0, mem_adr0}, 32'h05);
        check_eq("awr05_adr1", {24'b0, mem_adr1}, 32'h05);

        host_cycle(1'b0, 1'b1, 1'b0, 8'hA5, 0, "dwrA5", fall_cyc);
        check_eq("dwrA5_adr0", {24'b0, mem_adr0}, 32'h05);
        check_eq("dwrA5_adr1_inc", {24'b0, mem_adr1}, 32'h06);

        host_cycle(1'b1, 1'b0, 1'b0, 8'h85, 0, "awr85", fall_cyc);
        host_cycle(1'b0, 1'b1, 1'b1, 8'h00, 0, "drd85", fall_cyc);
        host_cycle(1'b1, 1'b0, 1'b1, 8'h00, 0, "ard", fall_cyc);

        host_cycle(1'b1, 1'b0, 1'b0, 8'hFF, 0, "awrFF", fall_cyc);
        host_cycle(1'b0, 1'b1, 1'b0, 8'h11, 0, "dwr11", fall_cyc);
        host_cycle(1'b0, 1'b1, 1'b0, 8'h22, 0, "dwr22", fall_cyc);
        check_eq("wrap_adr0", {24'b0, mem_adr0}, 32'hFF);
        check_eq("wrap_adr1", {24'b0, mem_adr1}, 32'h01);

        host_cycle(1'b1, 1'b1, 1'b0, 8'h33, 0, "both_lo", fall_cyc);
        check_eq("both_lo_adr0", {24'b0, mem_adr0}, 32'h33);
        check_eq("both_lo_adr1", {24'b0, mem_adr1}, 32'h33);

        host_cycle(1'b0, 1'b1, 1'b0, 8'h44, 1, "early_rel", fall_cyc);

        // Reset while a read sits in HOLD with the bus driven
        @(negedge clk);
        depp_write = 1'b1;
        depp_dstb  = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (depp_wait0) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq("hold_rd_reached", {31'b0, seen}, 32'd1);
        check_eq("hold_rd_drv", {31'b0, dut0.drv}, 32'd1);
        #3 rst = 1'b0;
        #1;
        check_eq("hold_rst_wait0", {31'b0, depp_wait0}, 32'd0);
        check_eq("hold_rst_wait1", {31'b0, depp_wait1}, 32'd0);
        check_eq("hold_rst_drv0",  {31'b0, dut0.drv}, 32'd0);
        check_eq("hold_rst_drv1",  {31'b0, dut1.drv}, 32'd0);
        check_eq("hold_rst_adr0",  {24'b0, mem_adr0}, 32'd0);
        check_eq("hold_rst_adr1",  {24'b0, mem_adr1}, 32'd0);
        depp_dstb = 1'b1;
        depp_write = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        addr_m0 = 8'h00;
        addr_m1 = 8'h00;
        repeat (2) @(negedge clk);

        // Reset while a data write is still in the synchronizers; the held strobe restarts it
        depp_write = 1'b0;
        host_drive = 1'b1;
        host_db    = 8'h77;
        depp_dstb  = 1'b0;
        @(negedge clk);
        #3 rst = 1'b0;
        #1;
        check_eq("midwr_rst_we0", {31'b0, mem_we0}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        host_cycle(1'b0, 1'b1, 1'b0, 8'h77, 0, "rst_restart", fall_cyc);
        host_cycle(1'b1, 1'b0, 1'b1, 8'h00, 0, "ard_end", fall_cyc);

        repeat (3) @(negedge clk);
        check_eq("wq0_drained", wq0.size(), 32'd0);
        check_eq("wq1_drained", wq1.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
